// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB-first, one bit per clock.
// Latency: accept edge to done pulse is WIDTH+1 cycles; one operation per WIDTH+2 cycles.
// Backpressure: start is sampled only while idle; requests during an operation are dropped, not queued.
//
// Build option: define SERIAL_ADD_SUB_EN to add the 'sub' port (two's-complement subtract).
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   op_a   in   [WIDTH-1:0] augend, captured on accept
//   op_b   in   [WIDTH-1:0] addend, captured on accept
//   cin    in   initial carry, captured on accept
//   sub    in   subtract select (SERIAL_ADD_SUB_EN builds only), captured on accept
//   busy   out  operation in flight (registered)
//   done   out  one-cycle result-valid pulse (registered)
//   sum    out  [WIDTH-1:0] result, held until the next result
//   cout   out  final carry (no-borrow flag when subtracting), held with sum

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra counter bit so WIDTH=1 still gets a 1-bit counter and the
  // post-increment value on the last bit (WIDTH) never wraps.
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_res_shift;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  // The shared full-adder cell.
  assign w_fa_s = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_fa_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
  // Written as shift/or so it stays legal for WIDTH=1.
  assign w_res_shift = (r_res >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // a - b = a + ~b + 1; the forced carry replaces cin when subtracting.
  assign w_b_load = sub ? ~op_b : op_b;
  assign w_c_load = sub | cin;
`else
  assign w_b_load = op_b;
  assign w_c_load = cin;
`endif

  // Sequencer and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res   <= w_res_shift;
          r_carry <= w_fa_c;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Result register and final carry are complete here; publish them
          // together so sum never shows a partially shifted value.
          r_sum   <= r_res;
          r_cout  <= r_carry;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered status. done is loaded from the DONE state, so the pulse is
  // visible during the IDLE cycle that follows it; that is also the first
  // cycle in which a new start can be sampled. busy rises right after the
  // accept edge and falls together with done unless a new start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      r_busy <= w_accept || (r_state == S_RUN) || (r_state == S_DONE);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus randomized bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
// Expected results come from plain integer arithmetic; timing from edge counts.
// Every check is an immediate assertion that counts and reports its failure.

module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sub_sel;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start1, a1, b1, cin1, busy1, done1, cout1;
  logic [0:0] sum1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         d8_cyc[$];
  logic [8:0] d8_res[$];
  int         d1_cyc[$];
  logic [1:0] d1_res[$];

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .op_a  (a8),
    .op_b  (b8),
    .cin   (cin8),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_sel),
`endif
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .op_a  (a1),
    .op_b  (b1),
    .cin   (cin1),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // Edge counter: after edge En has been applied, cyc reads n (relative to start of sim).
  always @(posedge clk) cyc <= cyc + 1;

  // Record every done pulse with the edge index it followed and the result shown.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      d8_cyc.push_back(cyc);
      d8_res.push_back({cout8, sum8});
    end
    if (done1 === 1'b1) begin
      d1_cyc.push_back(cyc);
      d1_res.push_back({cout1, sum1});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,sum} for the 8-bit instance.
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                      input logic c, input logic s);
    logic [8:0] r;
    if (s) r = {1'b0, a} - {1'b0, b} + 9'h100;
    else   r = {1'b0, a} + {1'b0, b} + {8'h00, c};
    return r;
  endfunction

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s, input bit hold, output int e0);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c; sub_sel = s;
    @(posedge clk);
    #1;
    e0 = cyc;
    if (!hold) start8 = 1'b0;
  endtask

  task automatic issue1(input logic a, input logic b, input logic c, output int e0);
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    @(posedge clk);
    #1;
    e0 = cyc;
    start1 = 1'b0;
  endtask

  task automatic get8(output int c, output logic [8:0] r, output bit got);
    got = 1'b0; c = 0; r = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      #1;
      if (d8_cyc.size() > 0) begin
        c = d8_cyc.pop_front();
        r = d8_res.pop_front();
        got = 1'b1;
      end
    end
  endtask

  task automatic get1(output int c, output logic [1:0] r, output bit got);
    got = 1'b0; c = 0; r = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      #1;
      if (d1_cyc.size() > 0) begin
        c = d1_cyc.pop_front();
        r = d1_res.pop_front();
        got = 1'b1;
      end
    end
  endtask

  initial begin
    int         e0, dc, bc;
    logic [8:0] r9;
    logic [1:0] r2;
    bit         got;
    logic [7:0] ra, rb;
    logic       rc;

    rst_n = 1'b0; sub_sel = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8",  sum8,  0);
    chk("rst_cout8", cout8, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1: full-adder truth table, done two edges after accept.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      issue1(v[2], v[1], v[0], e0);
      get1(dc, r2, got);
      chk("w1_got", got, 1);
      chk("w1_lat", dc - e0, 2);
      chk("w1_res", r2, 2'(v[2]) + 2'(v[1]) + 2'(v[0]));
    end

    // WIDTH=8: 0x5A+0x3C, latency and busy length.
    issue8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, e0);
    bc = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (busy8 === 1'b1) bc++;
    end
    chk("busy_len", bc, 10);
    get8(dc, r9, got);
    chk("5a3c_got", got, 1);
    chk("5a3c_lat", dc - e0, 9);
    chk("5a3c_res", r9, 9'h096);
    chk("5a3c_hold", {cout8, sum8}, 9'h096);

    // Back-to-back with start held: second accept lands on E10.
    issue8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, e0);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    get8(dc, r9, got);
    chk("b2b1_got", got, 1);
    chk("b2b1_lat", dc - e0, 9);
    chk("b2b1_res", r9, 9'h100);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    get8(dc, r9, got);
    chk("b2b2_got", got, 1);
    chk("b2b2_lat", dc - e0, 19);
    chk("b2b2_res", r9, 9'h1FF);

    // start pulsed mid-operation is ignored.
    issue8(8'h21, 8'h42, 1'b1, 1'b0, 1'b0, e0);
    repeat (3) @(posedge clk);
    #1;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h77; cin8 = 1'b0;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    get8(dc, r9, got);
    chk("ign_got", got, 1);
    chk("ign_lat", dc - e0, 9);
    chk("ign_res", r9, ref8(8'h21, 8'h42, 1'b1, 1'b0));
    repeat (15) @(negedge clk);
    chk("ign_one_done", d8_cyc.size(), 0);

    // Reset mid-operation: outputs clear at once, no done follows.
    issue8(8'h33, 8'h44, 1'b0, 1'b0, 1'b0, e0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_done", done8, 0);
    chk("arst_sum",  sum8,  0);
    chk("arst_cout", cout8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_no_done", d8_cyc.size(), 0);
    issue8(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, e0);
    get8(dc, r9, got);
    chk("post_rst_got", got, 1);
    chk("post_rst_res", r9, 9'h003);

`ifdef SERIAL_ADD_SUB_EN
    issue8(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, e0);
    get8(dc, r9, got);
    chk("sub_10_01", r9, 9'h10F);
    issue8(8'h01, 8'h02, 1'b1, 1'b1, 1'b0, e0);
    get8(dc, r9, got);
    chk("sub_01_02", r9, 9'h0FF);
    issue8(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, e0);
    get8(dc, r9, got);
    chk("add_cin_sub0", r9, 9'h003);
`endif

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic s;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      issue8(ra, rb, rc, s, 1'b0, e0);
      get8(dc, r9, got);
      chk("rnd_lat", dc - e0, 9);
      chk("rnd_res", r9, ref8(ra, rb, rc, s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
